mem_access_ctrl: RTL and testbench

- Sequencer between the CPU-side MAR/MDR registers and the asynchronous SRAM of the SLC-3 datapath.
- Accepts a single read or write request from the control FSM and drives the SRAM strobes with a fixed number of wait cycles.
- Returns read data registered, for the MDR load mux (memory input path), and signals completion with a one-cycle Ready pulse.
- The control FSM holds its MEM states until Ready is seen.

---
 rtl/slc3_mem_pkg.sv | 17 +
 rtl/mem_wait_counter.sv | 30 +++
 rtl/mem_access_ctrl.sv | 121 ++++++++++++
 tb/tb_mem_access_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and sizes for the SLC-3 memory access path.
package slc3_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } mem_state_t;

    localparam int MEM_ADDR_W = 16;
    localparam int MEM_DATA_W = 16;

    // Width of the wait-state counter; holds up to 15 access cycles.
    localparam int WAIT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter with a zero flag, used to time SRAM and I/O wait states.
module mem_wait_counter
    import slc3_mem_pkg::*;
#(
    parameter int WIDTH = WAIT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    // Load has priority over decrement; the count saturates at zero.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between MAR/MDR and the asynchronous SRAM: one access per request,
// fixed wait states, registered strobes and read data, one-cycle Ready pulse.
module mem_access_ctrl
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WData,
    output logic              Busy,
    output logic              Ready,
    output logic [DATA_W-1:0] RData,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic              Mem_CE_N,
    output logic              Mem_OE_N,
    output logic              Mem_WE_N,
    output logic [DATA_W-1:0] Mem_DOut,
    output logic              Mem_DOut_EN,
    input  logic [DATA_W-1:0] Mem_DIn
);

    if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
        $error("mem_access_ctrl: WAIT_CYCLES must be in 1..15");
    end

    localparam logic [WAIT_W-1:0] LOAD_VALUE = WAIT_W'(WAIT_CYCLES - 1);

    mem_state_t state;
    logic       op_write;
    logic       cnt_zero;
    logic       cnt_load;
    logic       cnt_dec;

    assign cnt_load = (state == SETUP);
    assign cnt_dec  = (state == ACCESS);

    mem_wait_counter #(
        .WIDTH(WAIT_W)
    ) u_wait (
        .Clk       (Clk),
        .Reset     (Reset),
        .load      (cnt_load),
        .dec       (cnt_dec),
        .load_value(LOAD_VALUE),
        .zero      (cnt_zero)
    );

    // Strobes are registered from the phase just completed, so each phase's
    // pin levels appear one cycle after the state enters it; OE and WE are
    // derived from the latched op bit so they can never be low together.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            op_write    <= 1'b0;
            Busy        <= 1'b0;
            Ready       <= 1'b0;
            RData       <= '0;
            Mem_Addr    <= '0;
            Mem_DOut    <= '0;
            Mem_CE_N    <= 1'b1;
            Mem_OE_N    <= 1'b1;
            Mem_WE_N    <= 1'b1;
            Mem_DOut_EN <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Ready       <= 1'b0;
                    Mem_CE_N    <= 1'b1;
                    Mem_OE_N    <= 1'b1;
                    Mem_WE_N    <= 1'b1;
                    Mem_DOut_EN <= 1'b0;
                    if (Req) begin
                        Mem_Addr <= Addr;
                        Mem_DOut <= WData;
                        op_write <= Wr;
                        Busy     <= 1'b1;
                        state    <= SETUP;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                SETUP: begin
                    Mem_CE_N    <= 1'b0;
                    Mem_OE_N    <= op_write;
                    Mem_WE_N    <= 1'b1;
                    Mem_DOut_EN <= op_write;
                    state       <= ACCESS;
                end
                ACCESS: begin
                    Mem_CE_N    <= 1'b0;
                    Mem_OE_N    <= op_write;
                    Mem_WE_N    <= ~op_write;
                    Mem_DOut_EN <= op_write;
                    if (cnt_zero) begin
                        state <= DONE;
                        if (!op_write) begin
                            RData <= Mem_DIn;
                        end
                    end
                end
                DONE: begin
                    Ready    <= 1'b1;
                    Mem_WE_N <= 1'b1;
                    Mem_OE_N <= 1'b1;
                    Busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a WAIT_CYCLES=2 and a WAIT_CYCLES=1 instance share
// stimulus; each drives its own SRAM model and is checked against a timeline model.
module tb_mem_access_ctrl;

    logic        Clk;
    logic        Reset;
    logic        Req;
    logic        Wr;
    logic [15:0] Addr;
    logic [15:0] WData;

    logic [1:0]  busy;
    logic [1:0]  ready;
    logic [1:0]  ce_n;
    logic [1:0]  oe_n;
    logic [1:0]  we_n;
    logic [1:0]  dout_en;
    logic [15:0] rdata    [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_dout [2];
    logic [15:0] mem_din  [2];

    logic [15:0] sram [2][65536];
    logic [15:0] mmem [2][65536];

    int          age     [2];
    logic        m_op    [2];
    logic [15:0] m_addr  [2];
    logic [15:0] m_dout  [2];
    logic [15:0] m_rdata [2];

    int   compared;
    int   mismatched;
    int   cyc;
    logic check_en;

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2)) dut0 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
        .Busy(busy[0]), .Ready(ready[0]), .RData(rdata[0]), .Mem_Addr(mem_addr[0]),
        .Mem_CE_N(ce_n[0]), .Mem_OE_N(oe_n[0]), .Mem_WE_N(we_n[0]),
        .Mem_DOut(mem_dout[0]), .Mem_DOut_EN(dout_en[0]), .Mem_DIn(mem_din[0])
    );

    mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(1)) dut1 (
        .Clk(Clk), .Reset(Reset), .Req(Req), .Wr(Wr), .Addr(Addr), .WData(WData),
        .Busy(busy[1]), .Ready(ready[1]), .RData(rdata[1]), .Mem_Addr(mem_addr[1]),
        .Mem_CE_N(ce_n[1]), .Mem_OE_N(oe_n[1]), .Mem_WE_N(we_n[1]),
        .Mem_DOut(mem_dout[1]), .Mem_DOut_EN(dout_en[1]), .Mem_DIn(mem_din[1])
    );

    assign mem_din[0] = sram[0][mem_addr[0]];
    assign mem_din[1] = sram[1][mem_addr[1]];

    initial Clk = 1'b0;
    // Free-running 10-unit clock.
    always #5 Clk = ~Clk;

    // Cycle index used only in messages.
    always @(posedge Clk) cyc <= cyc + 1;

    // SRAM cells take the driven data while chip and write enables are low.
    always @(posedge Clk) begin
        if (!ce_n[0] && !we_n[0] && dout_en[0]) sram[0][mem_addr[0]] <= mem_dout[0];
        if (!ce_n[1] && !we_n[1] && dout_en[1]) sram[1][mem_addr[1]] <= mem_dout[1];
    end

    function automatic logic [15:0] b16(input logic x);
        return {15'd0, x};
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%04h, expected 0x%04h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Model: age = cycles since the accepting edge (-1 when no access is in flight).
    // An access occupies ages 0..W+2; age W+2 is already idle and may accept again.
    task automatic modelStep(input int i);
        int w;
        int prev;
        w    = (i == 0) ? 2 : 1;
        prev = age[i];
        if (Reset) begin
            age[i]     = -1;
            m_op[i]    = 1'b0;
            m_addr[i]  = 16'h0000;
            m_dout[i]  = 16'h0000;
            m_rdata[i] = 16'h0000;
        end else if (((prev < 0) || (prev >= w + 2)) && Req) begin
            age[i]    = 0;
            m_op[i]   = Wr;
            m_addr[i] = Addr;
            m_dout[i] = WData;
        end else if (prev >= 0) begin
            age[i] = (prev + 1 > w + 2) ? -1 : prev + 1;
            if ((age[i] == w + 1) && !m_op[i]) m_rdata[i] = mmem[i][m_addr[i]];
            if ((age[i] == 2) && m_op[i]) mmem[i][m_addr[i]] = m_dout[i];
        end
    endtask

    // Advance both reference models on every clock edge.
    always @(posedge Clk) begin
        modelStep(0);
        modelStep(1);
    end

    task automatic compareInstance(input int i);
        int   w;
        int   a;
        logic rd;
        logic wr;
        w  = (i == 0) ? 2 : 1;
        a  = age[i];
        wr = m_op[i] && (a >= 0);
        rd = !m_op[i] && (a >= 0);
        checkOutput($sformatf("busy%0d", i),  b16(busy[i]),  b16((a >= 0) && (a <= w + 1)));
        checkOutput($sformatf("ready%0d", i), b16(ready[i]), b16(a == w + 2));
        checkOutput($sformatf("ce_n%0d", i),  b16(ce_n[i]),  b16(!((a >= 1) && (a <= w + 2))));
        checkOutput($sformatf("oe_n%0d", i),  b16(oe_n[i]),  b16(!(rd && (a >= 1) && (a <= w + 1))));
        checkOutput($sformatf("we_n%0d", i),  b16(we_n[i]),  b16(!(wr && (a >= 2) && (a <= w + 1))));
        checkOutput($sformatf("dout_en%0d", i), b16(dout_en[i]), b16(wr && (a >= 1) && (a <= w + 2)));
        checkOutput($sformatf("mem_addr%0d", i), mem_addr[i], m_addr[i]);
        checkOutput($sformatf("mem_dout%0d", i), mem_dout[i], m_dout[i]);
        checkOutput($sformatf("rdata%0d", i), rdata[i], m_rdata[i]);
        checkOutput($sformatf("we_oe_excl%0d", i), b16(!oe_n[i] && !we_n[i]), 16'h0000);
        checkOutput($sformatf("en_on_read%0d", i), b16(dout_en[i] && !oe_n[i]), 16'h0000);
    endtask

    // Compare every DUT output against the model in the middle of each cycle.
    always @(negedge Clk) begin
        if (check_en) begin
            compareInstance(0);
            compareInstance(1);
        end
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic applyStimulus(input logic wr, input logic [15:0] addr, input logic [15:0] wdata);
        Req   = 1'b1;
        Wr    = wr;
        Addr  = addr;
        WData = wdata;
        tick();
        Req = 1'b0;
    endtask

    // Directed scenarios followed by a randomized stretch.
    initial begin
        int n0;
        int n1;
        int r0a;
        int r0b;
        compared   = 0;
        mismatched = 0;
        cyc        = 0;
        check_en   = 1'b0;
        Reset      = 1'b1;
        Req        = 1'b0;
        Wr         = 1'b0;
        Addr       = 16'h0000;
        WData      = 16'h0000;
        for (int i = 0; i < 2; i++) begin
            age[i] = -1;
            for (int a = 0; a < 65536; a++) begin
                sram[i][a] = 16'(a) ^ 16'h5A5A;
                mmem[i][a] = 16'(a) ^ 16'h5A5A;
            end
            sram[i][16'h0042] = 16'hBEEF;
            mmem[i][16'h0042] = 16'hBEEF;
        end

        tick();
        check_en = 1'b1;
        tick();
        @(negedge Clk);
        checkOutput("rst_busy",  b16(busy[0]), 16'h0000);
        checkOutput("rst_ce_n",  b16(ce_n[0]), 16'h0001);
        checkOutput("rst_rdata", rdata[0], 16'h0000);
        Reset = 1'b0;
        tick();

        applyStimulus(1'b0, 16'h0042, 16'h0000);
        tick();
        @(negedge Clk);
        checkOutput("rd_oe_c1", b16(oe_n[0]), 16'h0000);
        tick();
        tick();
        @(negedge Clk);
        checkOutput("rd_oe_c3", b16(oe_n[0]), 16'h0000);
        checkOutput("rd_ready_c3", b16(ready[0]), 16'h0000);
        checkOutput("rd_w1_ready_c3", b16(ready[1]), 16'h0001);
        tick();
        @(negedge Clk);
        checkOutput("rd_ready_c4", b16(ready[0]), 16'h0001);
        checkOutput("rd_rdata_c4", rdata[0], 16'hBEEF);
        checkOutput("rd_oe_c4", b16(oe_n[0]), 16'h0001);
        checkOutput("rd_w1_ready_c4", b16(ready[1]), 16'h0000);
        checkOutput("rd_w1_rdata", rdata[1], 16'hBEEF);
        tick();
        @(negedge Clk);
        checkOutput("rd_ready_c5", b16(ready[0]), 16'h0000);
        tick();

        applyStimulus(1'b1, 16'h1234, 16'hA5A5);
        Addr  = 16'hFFFF;
        WData = 16'h0000;
        n0 = 0;
        n1 = 0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            @(negedge Clk);
            if (!we_n[0]) n0++;
            if (!we_n[1]) n1++;
            if (k <= 4) begin
                checkOutput("wr_addr_stable", mem_addr[0], 16'h1234);
                checkOutput("wr_dout_stable", mem_dout[0], 16'hA5A5);
            end
        end
        checkOutput("wr_we_cycles", 16'(n0), 16'd2);
        checkOutput("wr_w1_we_cycles", 16'(n1), 16'd1);
        checkOutput("wr_sram", sram[0][16'h1234], 16'hA5A5);
        checkOutput("wr_w1_sram", sram[1][16'h1234], 16'hA5A5);
        checkOutput("wr_rdata_kept", rdata[0], 16'hBEEF);

        applyStimulus(1'b0, 16'h0042, 16'h0000);
        tick();
        tick();
        Req   = 1'b1;
        Wr    = 1'b1;
        Addr  = 16'h3333;
        WData = 16'h1111;
        n0 = 0;
        n1 = 0;
        for (int k = 3; k <= 12; k++) begin
            tick();
            Req = 1'b0;
            @(negedge Clk);
            if (ready[0]) n0++;
            if (ready[1]) n1++;
        end
        checkOutput("busy_rej_ready", 16'(n0), 16'd1);
        checkOutput("busy_rej_w1_ready", 16'(n1), 16'd1);
        checkOutput("busy_rej_sram", sram[0][16'h3333], 16'h3333 ^ 16'h5A5A);

        Req   = 1'b1;
        Wr    = 1'b0;
        Addr  = 16'h0010;
        tick();
        Addr  = 16'h0011;
        r0a = -1;
        r0b = -1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (k == 6) Req = 1'b0;
            @(negedge Clk);
            if (ready[0]) begin
                if (r0a < 0) r0a = k;
                else if (r0b < 0) r0b = k;
            end
            if (k == 4) checkOutput("b2b_idle_gap", b16(busy[0]), 16'h0000);
            if (k == 5) checkOutput("b2b_rdata1", rdata[0], 16'h0010 ^ 16'h5A5A);
        end
        checkOutput("b2b_ready1_cycle", 16'(r0a), 16'd4);
        checkOutput("b2b_ready2_cycle", 16'(r0b), 16'd9);
        checkOutput("b2b_rdata2", rdata[0], 16'h0011 ^ 16'h5A5A);

        applyStimulus(1'b1, 16'h3000, 16'h7777);
        tick();
        Reset = 1'b1;
        tick();
        @(negedge Clk);
        checkOutput("midrst_we_n",  b16(we_n[0]), 16'h0001);
        checkOutput("midrst_ce_n",  b16(ce_n[0]), 16'h0001);
        checkOutput("midrst_en",    b16(dout_en[0]), 16'h0000);
        checkOutput("midrst_busy",  b16(busy[0]), 16'h0000);
        checkOutput("midrst_rdata", rdata[0], 16'h0000);
        checkOutput("midrst_addr",  mem_addr[0], 16'h0000);
        Reset = 1'b0;

        for (int k = 0; k < 600; k++) begin
            tick();
            Reset = ($urandom_range(0, 99) < 2);
            Req   = ($urandom_range(0, 99) < 45);
            Wr    = 1'($urandom_range(0, 1));
            Addr  = 16'($urandom_range(0, 63));
            WData = 16'($urandom);
        end
        Reset = 1'b0;
        Req   = 1'b0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
